// File: rtl/pc_gen_redirect.sv
// pc_gen_redirect: fetch PC generator with stall hold, branch/flush redirect and buffered redirect
module pc_gen_redirect #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter int INST_BYTES = 4,
  parameter int STALL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STALL_W-1:0] stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              pc_misaligned,
  output logic              redirect_pending
);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(INST_BYTES - 1);
  logic [ADDR_W-1:0] pend_target;
  logic unused_stall;
  assign unused_stall = ^stall;
  assign pc_misaligned = ce & |(pc & MASK);
  // PC update: flush > stall (buffer branch) > live branch > buffered branch > sequential
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_VECTOR;
      ce <= 1'b0;
      redirect_pending <= 1'b0;
      pend_target <= '0;
    end else begin
      ce <= 1'b1;
      if (!ce) pc <= RESET_VECTOR;
      else if (flush) begin
        pc <= flush_pc;
        redirect_pending <= 1'b0;
      end else if (stall[0]) begin
        if (branch_flag) begin
          redirect_pending <= 1'b1;
          pend_target <= branch_target;
        end
      end else if (branch_flag) begin
        pc <= branch_target;
        redirect_pending <= 1'b0;
      end else if (redirect_pending) begin
        pc <= pend_target;
        redirect_pending <= 1'b0;
      end else pc <= pc + STEP;
    end
  end
endmodule

// File: tb/tb_pc_gen_redirect.sv
// tb_pc_gen_redirect: directed table, random model-checked run, 16-bit wrap and async reset checks
module tb_pc_gen_redirect;
  localparam logic [31:0] RV = 32'hBFC00000;
  logic clk = 0, rst = 0, flush = 0, br = 0;
  logic [5:0] stall = 0;
  logic [31:0] fpc = 0, bt = 0, pc;
  logic ce, mis, pend;
  logic rst16 = 0, br16 = 0;
  logic [15:0] bt16 = 0, pc16;
  logic ce16, mis16, pend16;
  int pass_cnt = 0, total = 0;
  logic m_ce = 0;
  logic [31:0] m_pc = RV;
  logic [31:0] pend_q[$];

  always #5 clk = ~clk;

  pc_gen_redirect dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(fpc),
    .branch_flag(br), .branch_target(bt), .pc(pc), .ce(ce),
    .pc_misaligned(mis), .redirect_pending(pend)
  );

  pc_gen_redirect #(.ADDR_W(16), .RESET_VECTOR(16'hFFF8)) dut16 (
    .clk(clk), .rst(rst16), .stall(6'd0), .flush(1'b0), .flush_pc(16'd0),
    .branch_flag(br16), .branch_target(bt16), .pc(pc16), .ce(ce16),
    .pc_misaligned(mis16), .redirect_pending(pend16)
  );

  typedef struct {
    logic [5:0] stall;
    logic flush;
    logic [31:0] fpc;
    logic br;
    logic [31:0] bt;
    logic [31:0] pc;
    logic pend;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(logic [5:0] s, logic f, logic [31:0] fp, logic b, logic [31:0] t,
                              logic [31:0] p, logic pd);
    vec_t v;
    v.stall = s; v.flush = f; v.fpc = fp; v.br = b; v.bt = t; v.pc = p; v.pend = pd;
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_ce = 0;
    m_pc = RV;
    pend_q.delete();
  endtask

  task automatic step();
    if (!m_ce) begin
      m_ce = 1;
      m_pc = RV;
    end else if (flush) begin
      m_pc = fpc;
      pend_q.delete();
    end else if (stall[0]) begin
      if (br) begin
        pend_q.delete();
        pend_q.push_back(bt);
      end
    end else if (br) begin
      m_pc = bt;
      pend_q.delete();
    end else if (pend_q.size() != 0) m_pc = pend_q.pop_front();
    else m_pc = m_pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(string tag);
    chk({tag, "_pc"}, pc, m_pc);
    chk({tag, "_ce"}, {31'd0, ce}, {31'd0, m_ce});
    chk({tag, "_pend"}, {31'd0, pend}, {31'd0, pend_q.size() != 0});
    chk({tag, "_mis"}, {31'd0, mis}, {31'd0, m_ce && (m_pc % 4 != 0)});
  endtask

  initial begin
    add(0, 0, 0, 0, 0, 32'hBFC00000, 0);
    add(0, 0, 0, 0, 0, 32'hBFC00004, 0);
    add(0, 0, 0, 0, 0, 32'hBFC00008, 0);
    add(0, 0, 0, 0, 0, 32'hBFC0000C, 0);
    add(0, 0, 0, 0, 0, 32'hBFC00010, 0);
    add(1, 0, 0, 0, 0, 32'hBFC00010, 0);
    add(1, 0, 0, 0, 0, 32'hBFC00010, 0);
    add(1, 0, 0, 0, 0, 32'hBFC00010, 0);
    add(0, 0, 0, 0, 0, 32'hBFC00014, 0);
    add(1, 0, 0, 1, 32'h80001000, 32'hBFC00014, 1);
    add(1, 0, 0, 0, 0, 32'hBFC00014, 1);
    add(0, 0, 0, 0, 0, 32'h80001000, 0);
    add(0, 0, 0, 0, 0, 32'h80001004, 0);
    add(1, 0, 0, 1, 32'h80001000, 32'h80001004, 1);
    add(1, 0, 0, 1, 32'h80002000, 32'h80001004, 1);
    add(0, 0, 0, 0, 0, 32'h80002000, 0);
    add(1, 0, 0, 1, 32'h80003000, 32'h80002000, 1);
    add(1, 1, 32'hBFC00380, 1, 32'h80004000, 32'hBFC00380, 0);
    add(0, 0, 0, 0, 0, 32'hBFC00384, 0);
    add(1, 0, 0, 1, 32'h80005000, 32'hBFC00384, 1);
    add(0, 0, 0, 1, 32'h80006000, 32'h80006000, 0);
    add(6'b111110, 0, 0, 0, 0, 32'h80006004, 0);
    add(0, 0, 0, 0, 0, 32'h80006008, 0);

    #12;
    chk("rst_pc", pc, RV);
    chk("rst_ce", {31'd0, ce}, 32'd0);
    chk("rst_pend", {31'd0, pend}, 32'd0);
    chk("rst_mis", {31'd0, mis}, 32'd0);
    rst = 1;

    foreach (tbl[i]) begin
      stall = tbl[i].stall; flush = tbl[i].flush; fpc = tbl[i].fpc;
      br = tbl[i].br; bt = tbl[i].bt;
      step();
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("tbl%0d_ce", i), {31'd0, ce}, 32'd1);
      chk($sformatf("tbl%0d_pend", i), {31'd0, pend}, {31'd0, tbl[i].pend});
      chk($sformatf("tbl%0d_mis", i), {31'd0, mis}, 32'd0);
    end

    for (int i = 0; i < 300; i++) begin
      stall = 6'($urandom);
      stall[0] = ($urandom_range(0, 9) < 3);
      flush = ($urandom_range(0, 19) == 0);
      br = ($urandom_range(0, 4) == 0);
      fpc = $urandom & 32'hFFFFFFFC;
      bt = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0] = 2'b00;
      step();
      chk_model($sformatf("rnd%0d", i));
    end

    stall = 1; flush = 0; br = 1; bt = 32'h80001000;
    step();
    chk("pre_rst_pend", {31'd0, pend}, 32'd1);
    stall = 0; br = 0;
    #3 rst = 0;
    model_reset();
    #1;
    chk("arst_pc", pc, RV);
    chk("arst_ce", {31'd0, ce}, 32'd0);
    chk("arst_pend", {31'd0, pend}, 32'd0);
    chk("arst_mis", {31'd0, mis}, 32'd0);
    #2 rst = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("restart%0d_pc", i), pc, RV + 32'(4 * i));
      chk_model($sformatf("restart%0d", i));
    end

    #3 rst16 = 1;
    chk("w16_rst_ce", {31'd0, ce16}, 32'd0);
    chk("w16_rst_pc", {16'd0, pc16}, 32'h0000FFF8);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("w16_seq%0d_pc", i), {16'd0, pc16}, 32'(16'(16'hFFF8 + 16'(4 * i))));
      chk($sformatf("w16_seq%0d_ce", i), {31'd0, ce16}, 32'd1);
    end
    br16 = 1; bt16 = 16'h0006;
    @(posedge clk); #1;
    br16 = 0;
    chk("w16_br_pc", {16'd0, pc16}, 32'h00000006);
    chk("w16_br_mis", {31'd0, mis16}, 32'd1);
    chk("w16_br_pend", {31'd0, pend16}, 32'd0);
    @(posedge clk); #1;
    chk("w16_adv_pc", {16'd0, pc16}, 32'h0000000A);
    chk("w16_adv_mis", {31'd0, mis16}, 32'd1);
    br16 = 1; bt16 = 16'h0010;
    @(posedge clk); #1;
    br16 = 0;
    chk("w16_align_pc", {16'd0, pc16}, 32'h00000010);
    chk("w16_align_mis", {31'd0, mis16}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
